// File: rtl/and_32b_if.sv
// Operand/result bundle for the and_32b bitwise-AND unit.
// The master drives the operands; the slave (the AND unit) returns the result and the zero flag.
interface and_32b_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] And;
    logic             Zero;
    logic [WIDTH-1:0] And_q;
    logic             Zero_q;

    modport master (
        output A,
        output B,
        input  And,
        input  Zero,
        input  And_q,
        input  Zero_q
    );

    modport slave (
        input  A,
        input  B,
        output And,
        output Zero,
        output And_q,
        output Zero_q
    );
endinterface

// File: rtl/and_32b.sv
// Bitwise AND unit for the ALU logic-operations group: a zero-latency result and zero flag,
// plus a one-cycle registered copy of both for pipelined consumers.
module and_32b #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    and_32b_if.slave bus
);
    logic [WIDTH-1:0] and_w;
    logic             zero_w;
    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] and_q;
    logic             zero_d;
    logic             zero_q;

    // One independent 2-input AND per bit; there is no cross-bit dependency.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign and_w[i] = bus.A[i] & bus.B[i];
    end

    assign zero_w = ~|and_w;

    assign and_d  = and_w;
    assign zero_d = zero_w;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            and_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            and_q  <= and_d;
            zero_q <= zero_d;
        end
    end

    // The combinational outputs never see reset so they stay valid while it is held.
    assign bus.And    = and_w;
    assign bus.Zero   = zero_w;
    assign bus.And_q  = and_q;
    assign bus.Zero_q = zero_q;
endmodule

// File: tb/tb_and_32b.sv
// Directed self-checking bench for and_32b: combinational result/flag and the registered copy,
// including asynchronous reset behaviour mid-operation.
module tb_and_32b;
    localparam int WIDTH    = 32;
    localparam int HALF     = 20;
    localparam int MAX_SHOW = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    and_32b_if #(.WIDTH(WIDTH)) bus ();

    and_32b #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    task automatic test_reset();
        reset  = 1'b1;
        bus.A  = 32'h0000_0003;
        bus.B  = 32'h0000_0006;
        #3;
        checks++;
        if (bus.And_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_and_q: got %h expected %h", bus.And_q, 32'h0);
        end
        checks++;
        if (bus.Zero_q !== 1'b1) begin
            errors++;
            $display("FAIL reset_zero_q: got %b expected 1", bus.Zero_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.And_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold_and_q: got %h expected %h", bus.And_q, 32'h0);
        end
        checks++;
        if (bus.And !== 32'h0000_0002) begin
            errors++;
            $display("FAIL reset_comb_and: got %h expected %h", bus.And, 32'h0000_0002);
        end
        checks++;
        if (bus.Zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb_zero: got %b expected 0", bus.Zero);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_exhaustive_low_byte();
        logic [WIDTH-1:0] exp;
        int shown;
        shown = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                bus.A = WIDTH'(a);
                bus.B = WIDTH'(b);
                #10;
                exp = WIDTH'(a & b);
                checks++;
                if (bus.And !== exp || bus.Zero !== (exp == '0)) begin
                    errors++;
                    if (shown < MAX_SHOW) begin
                        shown++;
                        $display("FAIL low_byte a=%0d b=%0d: got And=%h Zero=%b expected And=%h Zero=%b",
                                 a, b, bus.And, bus.Zero, exp, (exp == '0));
                    end
                end
            end
        end
    endtask

    task automatic test_comb_directed();
        bus.A = 32'hFFFF_FFFF;
        bus.B = 32'h1234_5678;
        #10;
        checks++;
        if (bus.And !== 32'h1234_5678 || bus.Zero !== 1'b0) begin
            errors++;
            $display("FAIL comb_ones: got And=%h Zero=%b expected And=12345678 Zero=0", bus.And, bus.Zero);
        end
        bus.A = 32'hAAAA_AAAA;
        bus.B = 32'h5555_5555;
        #10;
        checks++;
        if (bus.And !== 32'h0 || bus.Zero !== 1'b1) begin
            errors++;
            $display("FAIL comb_alt: got And=%h Zero=%b expected And=00000000 Zero=1", bus.And, bus.Zero);
        end
        bus.A = 32'h8000_0000;
        bus.B = 32'hFFFF_FFFF;
        #10;
        checks++;
        if (bus.And !== 32'h8000_0000 || bus.Zero !== 1'b0) begin
            errors++;
            $display("FAIL comb_msb: got And=%h Zero=%b expected And=80000000 Zero=0", bus.And, bus.Zero);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        bus.A = 32'hFFFF_FFFF;
        bus.B = 32'h1234_5678;
        @(posedge clk);
        #1;
        checks++;
        if (bus.And_q !== 32'h1234_5678 || bus.Zero_q !== 1'b0) begin
            errors++;
            $display("FAIL reg_ones: got And_q=%h Zero_q=%b expected And_q=12345678 Zero_q=0", bus.And_q, bus.Zero_q);
        end
        @(negedge clk);
        bus.A = 32'hAAAA_AAAA;
        bus.B = 32'h5555_5555;
        #1;
        checks++;
        if (bus.And_q !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reg_hold: got And_q=%h expected 12345678", bus.And_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.And_q !== 32'h0 || bus.Zero_q !== 1'b1) begin
            errors++;
            $display("FAIL reg_alt: got And_q=%h Zero_q=%b expected And_q=00000000 Zero_q=1", bus.And_q, bus.Zero_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] va [4];
        logic [WIDTH-1:0] vb [4];
        logic [WIDTH-1:0] ve [4];
        va = '{32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_0000};
        vb = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_0001, 32'h0000_FFFF};
        ve = '{32'h0F0F_0F0F, 32'h0000_BEEF, 32'h0000_0001, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.A = va[i];
            bus.B = vb[i];
            @(posedge clk);
            #1;
            checks++;
            if (bus.And_q !== ve[i] || bus.Zero_q !== (ve[i] == '0)) begin
                errors++;
                $display("FAIL b2b_%0d: got And_q=%h Zero_q=%b expected And_q=%h Zero_q=%b",
                         i, bus.And_q, bus.Zero_q, ve[i], (ve[i] == '0));
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.A = 32'h8000_0001;
        bus.B = 32'h8000_0001;
        @(posedge clk);
        #1;
        checks++;
        if (bus.And_q !== 32'h8000_0001 || bus.Zero_q !== 1'b0) begin
            errors++;
            $display("FAIL mid_capture: got And_q=%h Zero_q=%b expected And_q=80000001 Zero_q=0", bus.And_q, bus.Zero_q);
        end
        #4;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.And_q !== 32'h0 || bus.Zero_q !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got And_q=%h Zero_q=%b expected And_q=00000000 Zero_q=1", bus.And_q, bus.Zero_q);
        end
        checks++;
        if (bus.And !== 32'h8000_0001 || bus.Zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_comb: got And=%h Zero=%b expected And=80000001 Zero=0", bus.And, bus.Zero);
        end
    endtask

    task automatic test_deassert();
        bus.A = 32'hF0F0_F0F0;
        bus.B = 32'hFF00_FF00;
        @(negedge clk);
        reset = 1'b0;
        #5;
        checks++;
        if (bus.And_q !== 32'h0) begin
            errors++;
            $display("FAIL deassert_early: got And_q=%h expected 00000000", bus.And_q);
        end
        #(HALF - 8);
        checks++;
        if (bus.And_q !== 32'h0 || bus.Zero_q !== 1'b1) begin
            errors++;
            $display("FAIL deassert_pre_edge: got And_q=%h Zero_q=%b expected And_q=00000000 Zero_q=1", bus.And_q, bus.Zero_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.And_q !== 32'hF000_F000 || bus.Zero_q !== 1'b0) begin
            errors++;
            $display("FAIL deassert_capture: got And_q=%h Zero_q=%b expected And_q=F000F000 Zero_q=0", bus.And_q, bus.Zero_q);
        end
    endtask

    initial begin
        #(HALF * 2 * 40000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exhaustive_low_byte();
        test_comb_directed();
        test_registered();
        test_back_to_back();
        test_reset_mid();
        test_deassert();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
